// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives imem_addr, queues {pc, instr} in a 2-deep buffer for decode.
// Latency: start -> first fetch next cycle -> out_valid one cycle later; sustains 1 instr/cycle when decode keeps up.
// Backpressure: out_ready low stalls fetch once both buffer slots are full; the PC holds until a slot frees.
module fetch_controller #(
    parameter int          MEM_DEPTH = 11,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        addr_err
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic [31:0] tail_pc;
    logic [31:0] tail_instr;

    logic in_range;
    logic pop;
    logic fetch_fire;
    logic range_trip;
    logic redirect_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        redirect_take = 1'b0;
        in_range      = (pc < DEPTH_W);
        out_valid     = (count != 2'd0) && !redirect;
        pop           = out_valid && out_ready;
        fetch_fire    = 1'b0;
        range_trip    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    redirect_take = 1'b1;
                end else if (!in_range) begin
                    range_trip = 1'b1;
                    state_nxt  = HALTED;
                end else if ((count != 2'd2) || pop) begin
                    fetch_fire = 1'b1;
                    if (imem_instr == HALT_WORD) begin
                        state_nxt = HALTED;
                    end
                end
            end
            HALTED: begin
                if (redirect) begin
                    redirect_take = 1'b1;
                    state_nxt     = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer is a head/tail pair; head registers double as the output and keep their value when emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            count      <= 2'd0;
            addr_err   <= 1'b0;
            head_pc    <= 32'h0;
            head_instr <= 32'h0;
            tail_pc    <= 32'h0;
            tail_instr <= 32'h0;
        end else if (redirect_take) begin
            pc       <= redirect_pc;
            count    <= 2'd0;
            addr_err <= 1'b0;
        end else begin
            if (fetch_fire) begin
                pc <= pc + 32'd1;
            end
            if (range_trip) begin
                addr_err <= 1'b1;
            end
            if (pop && fetch_fire) begin
                if (count == 2'd2) begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    tail_pc    <= pc;
                    tail_instr <= imem_instr;
                end else begin
                    head_pc    <= pc;
                    head_instr <= imem_instr;
                end
            end else if (pop) begin
                if (count == 2'd2) begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                end
                count <= count - 2'd1;
            end else if (fetch_fire) begin
                if (count == 2'd0) begin
                    head_pc    <= pc;
                    head_instr <= imem_instr;
                end else begin
                    tail_pc    <= pc;
                    tail_instr <= imem_instr;
                end
                count <= count + 2'd1;
            end
        end
    end

    assign imem_addr = pc;
    assign out_pc    = head_pc;
    assign out_instr = head_instr;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: 11-word memory model, word 5 is the halt word unless a test changes it.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        addr_err;

    logic [31:0] mem [0:15];
    int checks;
    int errors;

    fetch_controller #(
        .MEM_DEPTH(11),
        .RESET_PC(32'h0),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_ready(out_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halted(halted),
        .addr_err(addr_err)
    );

    assign imem_instr = (imem_addr < 32'd16) ? mem[imem_addr[3:0]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [31:0] word_of(input int idx);
        return (idx == 5) ? 32'hFFFF_FFFF : 32'h1000_0000 + 32'(idx);
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        smp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 00000000", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 00000000", out_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 00000000", imem_addr); end
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        smp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency_t1: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_addr: got %h expected 00000000", imem_addr); end
        cyc();
        smp();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_latency_t2: got %b expected 1", out_valid); end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) begin
                checks++; if (out_pc !== 32'(n)) begin errors++; $display("FAIL stream_pc: got %h expected %h", out_pc, 32'(n)); end
                checks++; if (out_instr !== word_of(n)) begin errors++; $display("FAIL stream_instr: got %h expected %h", out_instr, word_of(n)); end
                if (n == 5) begin
                    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stream_halted_at_halt_word: got %b expected 1", halted); end
                end
                n++;
            end
            cyc();
            smp();
        end
        checks++; if (n != 6) begin errors++; $display("FAIL stream_count: got %0d expected 6", n); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stream_halted: got %b expected 1", halted); end
        checks++; if (imem_addr !== 32'd6) begin errors++; $display("FAIL stream_final_pc: got %h expected 00000006", imem_addr); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL stream_addr_err: got %b expected 0", addr_err); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        smp();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 00000000", out_pc); end
        checks++; if (imem_addr !== 32'd2) begin errors++; $display("FAIL bp_pc_held: got %h expected 00000002", imem_addr); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_gap: got valid %b expected 1 at entry %0d", out_valid, k); end
            checks++; if (out_pc !== 32'(k)) begin errors++; $display("FAIL bp_pc: got %h expected %h", out_pc, 32'(k)); end
            checks++; if (out_instr !== word_of(k)) begin errors++; $display("FAIL bp_instr: got %h expected %h", out_instr, word_of(k)); end
            cyc();
            smp();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %b expected 1", halted); end
    endtask

    task automatic test_redirect();
        int n;
        mem[5] = 32'h1000_0005;
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
        cyc();
        cyc();
        out_ready = 1'b0;
        smp();
        checks++; if (out_pc !== 32'd2) begin errors++; $display("FAIL redir_pre_head: got %h expected 00000002", out_pc); end
        redirect = 1'b1;
        redirect_pc = 32'd8;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_masked: got %b expected 0", out_valid); end
        cyc();
        redirect = 1'b0;
        smp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL redir_new_pc: got %h expected 00000008", imem_addr); end
        n = 8;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) begin
                checks++; if (out_pc !== 32'(n)) begin errors++; $display("FAIL redir_pc: got %h expected %h", out_pc, 32'(n)); end
                checks++; if (out_instr !== word_of(n)) begin errors++; $display("FAIL redir_instr: got %h expected %h", out_instr, word_of(n)); end
                n++;
            end
            cyc();
            smp();
        end
        checks++; if (n != 11) begin errors++; $display("FAIL redir_count: got last+1 %0d expected 11", n); end
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL redir_addr_err: got %b expected 1", addr_err); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL redir_halted: got %b expected 1", halted); end
        checks++; if (imem_addr !== 32'd11) begin errors++; $display("FAIL redir_pc_hold: got %h expected 0000000b", imem_addr); end

        // Recover from the address error by redirecting back to 0.
        redirect = 1'b1;
        redirect_pc = 32'd0;
        cyc();
        redirect = 1'b0;
        smp();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL recover_addr_err: got %b expected 0", addr_err); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL recover_halted: got %b expected 0", halted); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL recover_pc: got %h expected 00000000", imem_addr); end
        cyc();
        smp();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL recover_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL recover_out_pc: got %h expected 00000000", out_pc); end
        checks++; if (out_instr !== 32'h1000_0000) begin errors++; $display("FAIL recover_instr: got %h expected 10000000", out_instr); end
        mem[5] = 32'hFFFF_FFFF;
    endtask

    task automatic test_redirect_illegal();
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        smp();
        redirect = 1'b1;
        redirect_pc = 32'd20;
        cyc();
        redirect = 1'b0;
        smp();
        checks++; if (imem_addr !== 32'd20) begin errors++; $display("FAIL illegal_pc: got %h expected 00000014", imem_addr); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL illegal_err_early: got %b expected 0", addr_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_valid1: got %b expected 0", out_valid); end
        cyc();
        smp();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL illegal_addr_err: got %b expected 1", addr_err); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL illegal_halted: got %b expected 1", halted); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_push: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'd20) begin errors++; $display("FAIL illegal_pc_hold: got %h expected 00000014", imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        smp();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        smp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h expected 00000000", imem_addr); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL midrst_instr: got %h expected 00000000", out_instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL midrst_halted: got %b expected 0", halted); end
        repeat (3) cyc();
        smp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle_valid: got %b expected 0", out_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_idle_pc: got %h expected 00000000", imem_addr); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        smp();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_restart_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL midrst_restart_pc: got %h expected 00000000", out_pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[5] = 32'hFFFF_FFFF;
        rst = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
